// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_bridge
// Purpose  : APB3 initiator. Turns a single-outstanding request/response
//            command interface into APB3 transfers, decodes each address
//            against the APB and DUT windows, and aborts transfers whose
//            wait states exceed MAX_WAIT_STATES.
// Ports    : clk, rst                  - clock, synchronous active-high reset
//            req_valid/ready/write/addr/wdata - command channel
//            rsp_valid/rdata/slverr/decerr/timeout - response channel
//                                       (rsp_valid is a one-cycle pulse)
//            PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY/PSLVERR - APB3
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_bridge #(
    parameter logic [31:0] DUT_START_ADDRESS = 32'h8c000000,
    parameter logic [31:0] DUT_END_ADDRESS   = 32'h8c000598,
    parameter logic [31:0] APB_START_ADDRESS = 32'h8c000000,
    parameter logic [31:0] APB_END_ADDRESS   = 32'h8c001000,
    parameter int          MAX_WAIT_STATES   = 32
) (
    input  logic        clk,
    input  logic        rst,
    // command channel
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    // response channel
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_slverr,
    output logic        rsp_decerr,
    output logic        rsp_timeout,
    // APB3
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    localparam int          c_WAIT_W   = $clog2(MAX_WAIT_STATES + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MAX_WAIT_STATES);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE = c_WAIT_W'(1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETUP  = 2'd1;
    localparam logic [1:0] c_ACCESS = 2'd2;
    localparam logic [1:0] c_RESP   = 2'd3;

    logic [1:0]          state_q,     state_d;
    logic [c_WAIT_W-1:0] wait_cnt_q,  wait_cnt_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;
    logic                slverr_q,    slverr_d;
    logic                decerr_q,    decerr_d;
    logic                timeout_q,   timeout_d;
    logic                psel_q,      psel_d;
    logic                penable_q,   penable_d;
    logic                pwrite_q,    pwrite_d;
    logic [31:0]         paddr_q,     paddr_d;
    logic [31:0]         pwdata_q,    pwdata_d;

    logic w_misaligned;
    logic w_in_apb;
    logic w_in_dut;

    assign w_misaligned = (req_addr[1:0] != 2'b00);
    assign w_in_apb     = (req_addr >= APB_START_ADDRESS) && (req_addr <= APB_END_ADDRESS);
    assign w_in_dut     = (req_addr >= DUT_START_ADDRESS) && (req_addr <= DUT_END_ADDRESS);

    // All outputs are registers; the next-state logic below computes their
    // values for the state being entered, so each output lines up with the
    // state it belongs to.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        slverr_d    = 1'b0;
        decerr_d    = 1'b0;
        timeout_d   = 1'b0;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;

        case (state_q)
            c_IDLE: begin
                if (req_valid) begin
                    if (w_misaligned || !w_in_apb) begin
                        state_d     = c_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = 32'h0;
                        decerr_d    = 1'b1;
                    end else if (!w_in_dut) begin
                        // Default slave: complete with zero data, bus untouched.
                        state_d     = c_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = 32'h0;
                    end else begin
                        // Only DUT-bound commands load the APB address/data
                        // registers, so the bus is quiet for the other cases.
                        state_d  = c_SETUP;
                        psel_d   = 1'b1;
                        pwrite_d = req_write;
                        paddr_d  = req_addr;
                        pwdata_d = req_wdata;
                    end
                end
            end

            c_SETUP: begin
                state_d   = c_ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end

            c_ACCESS: begin
                if (PREADY) begin
                    state_d     = c_RESP;
                    rsp_valid_d = 1'b1;
                    slverr_d    = PSLVERR;
                    rsp_rdata_d = (!pwrite_q && !PSLVERR) ? PRDATA : 32'h0;
                end else if (wait_cnt_q == c_WAIT_MAX) begin
                    state_d     = c_RESP;
                    rsp_valid_d = 1'b1;
                    timeout_d   = 1'b1;
                    rsp_rdata_d = 32'h0;
                end else begin
                    wait_cnt_d = wait_cnt_q + c_WAIT_ONE;
                    psel_d     = 1'b1;
                    penable_d  = 1'b1;
                end
            end

            c_RESP: begin
                state_d    = c_IDLE;
                wait_cnt_d = '0;
            end

            default: begin
                state_d    = c_IDLE;
                wait_cnt_d = '0;
            end
        endcase

        req_ready_d = (state_d == c_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= c_IDLE;
            wait_cnt_q  <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            slverr_q    <= 1'b0;
            decerr_q    <= 1'b0;
            timeout_q   <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= 32'h0;
            pwdata_q    <= 32'h0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            slverr_q    <= slverr_d;
            decerr_q    <= decerr_d;
            timeout_q   <= timeout_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_slverr  = slverr_q;
    assign rsp_decerr  = decerr_q;
    assign rsp_timeout = timeout_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master_bridge
// Purpose  : Directed self-checking bench for apb_master_bridge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master_bridge;

    localparam int MAXW = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_slverr, rsp_decerr, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [31:0] PADDR, PWDATA, PRDATA;

    int n_vec = 0;
    int n_err = 0;

    apb_master_bridge dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_slverr (rsp_slverr),
        .rsp_decerr (rsp_decerr),
        .rsp_timeout(rsp_timeout),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    always #5 clk = ~clk;

    // Presents one command and returns just after the accepting edge.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
        int k;
        k = 0;
        @(negedge clk);
        while (!req_ready && k < 60) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (req_ready !== 1'b1) begin
            $display("FAIL issue_ready got=%b exp=1", req_ready);
            n_err++;
        end
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({req_ready, rsp_valid, PSEL, PENABLE, PWRITE, rsp_slverr, rsp_decerr, rsp_timeout} !== 8'b1000_0000) begin
            $display("FAIL reset_ctrl got=%b exp=10000000",
                     {req_ready, rsp_valid, PSEL, PENABLE, PWRITE, rsp_slverr, rsp_decerr, rsp_timeout});
            n_err++;
        end
        n_vec++;
        if ({PADDR, PWDATA, rsp_rdata} !== 96'h0) begin
            $display("FAIL reset_data got=%h/%h/%h exp=0", PADDR, PWDATA, rsp_rdata);
            n_err++;
        end
        rst = 1'b0;
    endtask

    task automatic test_write;
        PREADY = 1'b1; PSLVERR = 1'b0;
        issue(1'b1, 32'h8c000010, 32'h12345678);
        @(negedge clk);  // N+1: SETUP
        n_vec++;
        if ({PSEL, PENABLE, PWRITE, req_ready, rsp_valid} !== 5'b10100 || PADDR !== 32'h8c000010 || PWDATA !== 32'h12345678) begin
            $display("FAIL write_setup got=%b %h %h exp=10100 8c000010 12345678",
                     {PSEL, PENABLE, PWRITE, req_ready, rsp_valid}, PADDR, PWDATA);
            n_err++;
        end
        @(negedge clk);  // N+2: ACCESS
        n_vec++;
        if ({PSEL, PENABLE, rsp_valid} !== 3'b110 || PWDATA !== 32'h12345678) begin
            $display("FAIL write_access got=%b %h exp=110 12345678", {PSEL, PENABLE, rsp_valid}, PWDATA);
            n_err++;
        end
        @(negedge clk);  // N+3: RESP
        n_vec++;
        if ({rsp_valid, rsp_slverr, rsp_decerr, rsp_timeout, PSEL, PENABLE, req_ready} !== 7'b1000000 || rsp_rdata !== 32'h0) begin
            $display("FAIL write_resp got=%b %h exp=1000000 0",
                     {rsp_valid, rsp_slverr, rsp_decerr, rsp_timeout, PSEL, PENABLE, req_ready}, rsp_rdata);
            n_err++;
        end
        @(negedge clk);  // back in IDLE, APB fields hold
        n_vec++;
        if ({rsp_valid, req_ready, PWRITE} !== 3'b011 || PADDR !== 32'h8c000010 || PWDATA !== 32'h12345678) begin
            $display("FAIL write_idle_hold got=%b %h %h exp=011 8c000010 12345678",
                     {rsp_valid, req_ready, PWRITE}, PADDR, PWDATA);
            n_err++;
        end
    endtask

    task automatic test_read_wait;
        bit bad;
        PREADY = 1'b0; PRDATA = 32'h0;
        issue(1'b0, 32'h8c000598, 32'h0);
        @(negedge clk);  // SETUP
        n_vec++;
        if ({PSEL, PENABLE, PWRITE} !== 3'b100 || PADDR !== 32'h8c000598) begin
            $display("FAIL read_setup got=%b %h exp=100 8c000598", {PSEL, PENABLE, PWRITE}, PADDR);
            n_err++;
        end
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if ({PSEL, PENABLE, rsp_valid} !== 3'b110 || PADDR !== 32'h8c000598) bad = 1'b1;
            PREADY = (i == 5);
            PRDATA = (i == 5) ? 32'hCAFEF00D : 32'h11111111;
        end
        n_vec++;
        if (bad) begin
            $display("FAIL read_wait_stable got=unstable exp=PSEL/PENABLE=1 PADDR=8c000598");
            n_err++;
        end
        @(negedge clk);
        PREADY = 1'b0;
        n_vec++;
        if ({rsp_valid, rsp_slverr, rsp_decerr, rsp_timeout, PSEL} !== 5'b10000 || rsp_rdata !== 32'hCAFEF00D) begin
            $display("FAIL read_wait_resp got=%b %h exp=10000 cafef00d",
                     {rsp_valid, rsp_slverr, rsp_decerr, rsp_timeout, PSEL}, rsp_rdata);
            n_err++;
        end
        @(negedge clk);
        n_vec++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'hCAFEF00D) begin
            $display("FAIL rdata_hold got=%b %h exp=0 cafef00d", rsp_valid, rsp_rdata);
            n_err++;
        end
    endtask

    // Commands that never reach the DUT: response comes the cycle after accept.
    task automatic test_decode;
        logic [31:0] addrs [4];
        logic        dec   [4];
        addrs[0] = 32'h8c000800; dec[0] = 1'b0;
        addrs[1] = 32'h8c001000; dec[1] = 1'b0;
        addrs[2] = 32'h8c001004; dec[2] = 1'b1;
        addrs[3] = 32'h8c000002; dec[3] = 1'b1;
        PREADY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, addrs[i], 32'h0);
            @(negedge clk);
            n_vec++;
            if ({rsp_valid, rsp_decerr, rsp_slverr, rsp_timeout, PSEL, PENABLE} !== {1'b1, dec[i], 4'b0000} || rsp_rdata !== 32'h0) begin
                $display("FAIL decode_%h got=%b %h exp=%b 0", addrs[i],
                         {rsp_valid, rsp_decerr, rsp_slverr, rsp_timeout, PSEL, PENABLE}, rsp_rdata, {1'b1, dec[i], 4'b0000});
                n_err++;
            end
            @(negedge clk);
            n_vec++;
            if ({PSEL, rsp_valid, req_ready} !== 3'b001) begin
                $display("FAIL decode_after_%h got=%b exp=001", addrs[i], {PSEL, rsp_valid, req_ready});
                n_err++;
            end
        end
    endtask

    task automatic test_slverr;
        PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'hDEADBEEF;
        issue(1'b0, 32'h8c000020, 32'h0);
        repeat (3) @(negedge clk);
        n_vec++;
        if ({rsp_valid, rsp_slverr, rsp_decerr, rsp_timeout} !== 4'b1100 || rsp_rdata !== 32'h0) begin
            $display("FAIL slverr got=%b %h exp=1100 0", {rsp_valid, rsp_slverr, rsp_decerr, rsp_timeout}, rsp_rdata);
            n_err++;
        end
        PSLVERR = 1'b0;
    endtask

    // Timeout: SETUP, then MAX+1 ACCESS cycles, response in the next one.
    task automatic test_timeout;
        int cyc;
        PREADY = 1'b0; PRDATA = 32'h5555AAAA;
        issue(1'b0, 32'h8c000100, 32'h0);
        @(negedge clk);
        cyc = 0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                cyc = i;
                break;
            end
        end
        n_vec++;
        if (cyc !== MAXW + 2) begin
            $display("FAIL timeout_latency got=%0d exp=%0d", cyc, MAXW + 2);
            n_err++;
        end
        n_vec++;
        if ({rsp_timeout, rsp_slverr, rsp_decerr, PSEL, PENABLE} !== 5'b10000 || rsp_rdata !== 32'h0) begin
            $display("FAIL timeout_flags got=%b %h exp=10000 0",
                     {rsp_timeout, rsp_slverr, rsp_decerr, PSEL, PENABLE}, rsp_rdata);
            n_err++;
        end
    endtask

    task automatic test_last_wait;
        bit early;
        PREADY = 1'b0; PRDATA = 32'h0BADCAFE;
        issue(1'b0, 32'h8c000104, 32'h0);
        @(negedge clk);
        early = 1'b0;
        for (int i = 1; i <= MAXW + 1; i++) begin
            @(negedge clk);
            if (rsp_valid || !PENABLE) early = 1'b1;
            PREADY = (i == MAXW + 1);
        end
        @(negedge clk);
        PREADY = 1'b0;
        n_vec++;
        if (early || {rsp_valid, rsp_timeout, rsp_slverr} !== 3'b100 || rsp_rdata !== 32'h0BADCAFE) begin
            $display("FAIL last_wait got=early%0d %b %h exp=early0 100 0badcafe",
                     early, {rsp_valid, rsp_timeout, rsp_slverr}, rsp_rdata);
            n_err++;
        end
    endtask

    task automatic test_reset_mid;
        PREADY = 1'b0;
        issue(1'b1, 32'h8c000200, 32'hA5A5A5A5);
        repeat (4) @(negedge clk);  // SETUP + a few waits
        n_vec++;
        if ({PSEL, PENABLE} !== 2'b11) begin
            $display("FAIL rstmid_access got=%b exp=11", {PSEL, PENABLE});
            n_err++;
        end
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({PSEL, PENABLE, rsp_valid, req_ready} !== 4'b0001) begin
            $display("FAIL rstmid_drop got=%b exp=0001", {PSEL, PENABLE, rsp_valid, req_ready});
            n_err++;
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({PSEL, PENABLE, rsp_valid, req_ready} !== 4'b0001) begin
            $display("FAIL rstmid_release got=%b exp=0001", {PSEL, PENABLE, rsp_valid, req_ready});
            n_err++;
        end
        PREADY = 1'b1;
        issue(1'b1, 32'h8c000204, 32'h00C0FFEE);
        repeat (3) @(negedge clk);
        n_vec++;
        if ({rsp_valid, rsp_timeout, rsp_slverr, rsp_decerr} !== 4'b1000 || PWDATA !== 32'h00C0FFEE) begin
            $display("FAIL rstmid_recover got=%b %h exp=1000 00c0ffee",
                     {rsp_valid, rsp_timeout, rsp_slverr, rsp_decerr}, PWDATA);
            n_err++;
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        PRDATA = 32'h0; PREADY = 1'b0; PSLVERR = 1'b0;
        test_reset;
        test_write;
        test_read_wait;
        test_decode;
        test_slverr;
        test_timeout;
        test_last_wait;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
